// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, baud divisor helper and frame constants.
// Used by both the transmitter and the system receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int   DATA_BITS = 8;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit buffer for uart_tx. With UART_TX_FIFO_EN defined it is a DEPTH-entry
// circular FIFO; otherwise a single holding register with a full flag.
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] wr_data,
    input  logic       push,
    input  logic       pop,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);

`ifdef UART_TX_FIFO_EN
    localparam int PTR_W = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
`else
    logic [7:0] hold;
    logic       hold_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hold_full <= 1'b0;
        else     hold_full <= push | (hold_full & ~pop);
    end

    always_ff @(posedge clk) begin
        if (push) hold <= wr_data;
    end

    assign rd_data = hold;
    assign full    = hold_full;
    assign empty   = ~hold_full;
`endif

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter, LSB first, idle-high registered line output.
// Buffer depth: FIFO_DEPTH entries when UART_TX_FIFO_EN is defined, else one holding register.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    // tx_done is registered, so it is armed one cycle before the final stop cycle.
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(CLKS_PER_BIT - 2);

    if (CLKS_PER_BIT < 2) begin : g_baud_chk
        $error("uart_tx: CLK_FREQ / BAUD_RATE must be at least 2");
    end

    uart_state_t        state, state_n;
    logic [7:0]         shift, shift_n;
    logic [CNT_W-1:0]   clk_cnt, clk_cnt_n;
    logic [2:0]         bit_cnt, bit_cnt_n;
    logic               tx_q, tx_n;
    logic               done_q, done_n;
    logic               pop;
    logic               push;
    logic [7:0]         fifo_data;
    logic               fifo_full;
    logic               fifo_empty;
    logic               bit_end;

    assign push = valid & ~fifo_full;

    uart_tx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_data (data_in),
        .push    (push),
        .pop     (pop),
        .rd_data (fifo_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            tx_q    <= STOP_LVL;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            clk_cnt <= clk_cnt_n;
            bit_cnt <= bit_cnt_n;
            tx_q    <= tx_n;
            done_q  <= done_n;
        end
    end

    always_ff @(posedge clk) begin
        shift <= shift_n;
    end

    assign bit_end = (clk_cnt == CNT_LAST);

    always_comb begin
        state_n   = state;
        shift_n   = shift;
        clk_cnt_n = clk_cnt + CNT_W'(1);
        bit_cnt_n = bit_cnt;
        tx_n      = tx_q;
        done_n    = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                clk_cnt_n = '0;
                tx_n      = STOP_LVL;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_data;
                    tx_n    = START_LVL;
                    state_n = START;
                end
            end
            START: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    bit_cnt_n = '0;
                    tx_n      = shift[0];
                    shift_n   = shift >> 1;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    if (bit_cnt == 3'(DATA_BITS - 1)) begin
                        tx_n    = STOP_LVL;
                        state_n = STOP;
                    end else begin
                        tx_n      = shift[0];
                        shift_n   = shift >> 1;
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
            end
            STOP: begin
                done_n = (clk_cnt == CNT_DONE);
                if (bit_end) begin
                    clk_cnt_n = '0;
                    // Chain straight into the next start bit so frames have no idle gap.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_n = fifo_data;
                        tx_n    = START_LVL;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = STOP_LVL;
            end
        endcase
    end

    assign tx      = tx_q;
    assign tx_done = done_q;
    assign ready   = ~fifo_full;
    assign busy    = (state != IDLE) || !fifo_empty;

endmodule
